// File: rtl/mdu_ctrl_if.sv
// rtl/mdu_ctrl_if.sv - execute-stage request/write-back bundle between core and mdu_ctrl
interface mdu_ctrl_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
);
    logic                      start;
    logic [2:0]                op;
    logic [DATA_WIDTH-1:0]     rs1_data;
    logic [DATA_WIDTH-1:0]     rs2_data;
    logic [REG_ADDR_WIDTH-1:0] rd_addr;
    logic                      flush;
    logic                      busy;
    logic                      done;
    logic                      reg_wen;
    logic [REG_ADDR_WIDTH-1:0] reg_waddr;
    logic [DATA_WIDTH-1:0]     result;

    modport master (
        output start, op, rs1_data, rs2_data, rd_addr, flush,
        input  busy, done, reg_wen, reg_waddr, result
    );

    modport slave (
        input  start, op, rs1_data, rs2_data, rd_addr, flush,
        output busy, done, reg_wen, reg_waddr, result
    );
endinterface

// File: rtl/mdu_ctrl.sv
// rtl/mdu_ctrl.sv - iterative RV32M multiply/divide sequencer (shift-add / restoring divide)
module mdu_ctrl #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CNT_WIDTH      = 5
) (
    input logic     clk,
    input logic     rst,
    mdu_ctrl_if.slave bus
);
    localparam int W = DATA_WIDTH;
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CALC  = 2'd1;
    localparam logic [1:0] S_FIXUP = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(W - 1);
    localparam logic [W-1:0] INT_MIN = {1'b1, {(W-1){1'b0}}};

    logic [1:0]                state_q, state_d;
    logic [CNT_WIDTH-1:0]      cnt_q, cnt_d;
    logic [2:0]                op_q, op_d;
    logic [REG_ADDR_WIDTH-1:0] rd_q, rd_d;
    logic                      neg_a_q, neg_a_d, neg_b_q, neg_b_d;
    logic [W-1:0]              opnd_q, opnd_d;     // multiplicand or divisor magnitude
    logic [2*W-1:0]            prod_q, prod_d;     // product, or dividend shifting into quotient
    logic [W-1:0]              rem_q, rem_d;
    logic [W-1:0]              res_q, res_d;
    logic [W-1:0]              result_q, result_d;

    logic           sign_a, sign_b, neg_a, neg_b, is_div, div_zero, div_ovf, special;
    logic [W-1:0]   a_mag, b_mag, special_res, quo_fix, rem_fix, fix_res;
    logic [W:0]     mul_sum, div_shift, div_diff;
    logic [2*W-1:0] mul_fix;

    assign sign_a   = (bus.op == 3'b001) || (bus.op == 3'b010) || (bus.op == 3'b100) || (bus.op == 3'b110);
    assign sign_b   = (bus.op == 3'b001) || (bus.op == 3'b100) || (bus.op == 3'b110);
    assign neg_a    = sign_a && bus.rs1_data[W-1];
    assign neg_b    = sign_b && bus.rs2_data[W-1];
    assign a_mag    = neg_a ? -bus.rs1_data : bus.rs1_data;
    assign b_mag    = neg_b ? -bus.rs2_data : bus.rs2_data;
    assign is_div   = bus.op[2];
    assign div_zero = (bus.rs2_data == '0);
    assign div_ovf  = !bus.op[0] && (bus.rs1_data == INT_MIN) && (&bus.rs2_data);
    assign special  = is_div && (div_zero || div_ovf);
    assign special_res = div_zero ? (bus.op[1] ? bus.rs1_data : {W{1'b1}})
                                  : (bus.op[1] ? {W{1'b0}} : INT_MIN);

    assign mul_sum   = {1'b0, prod_q[2*W-1:W]} + (prod_q[0] ? {1'b0, opnd_q} : {(W+1){1'b0}});
    assign div_shift = {rem_q, prod_q[W-1]};
    assign div_diff  = div_shift - {1'b0, opnd_q};

    assign mul_fix = (neg_a_q ^ neg_b_q) ? -prod_q : prod_q;
    assign quo_fix = (neg_a_q ^ neg_b_q) ? -prod_q[W-1:0] : prod_q[W-1:0];
    assign rem_fix = neg_a_q ? -rem_q : rem_q;
    assign fix_res = op_q[2] ? (op_q[1] ? rem_fix : quo_fix)
                             : ((op_q[1:0] == 2'b00) ? mul_fix[W-1:0] : mul_fix[2*W-1:W]);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        rd_d     = rd_q;
        neg_a_d  = neg_a_q;
        neg_b_d  = neg_b_q;
        opnd_d   = opnd_q;
        prod_d   = prod_q;
        rem_d    = rem_q;
        res_d    = res_q;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start && !bus.flush) begin
                    op_d    = bus.op;
                    rd_d    = bus.rd_addr;
                    neg_a_d = neg_a;
                    neg_b_d = neg_b;
                    cnt_d   = '0;
                    opnd_d  = is_div ? b_mag : a_mag;
                    prod_d  = {{W{1'b0}}, (is_div ? a_mag : b_mag)};
                    rem_d   = '0;
                    if (special) begin
                        res_d   = special_res;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                cnt_d = cnt_q + 1'b1;
                if (op_q[2]) begin
                    // Restore by keeping the shifted value when the trial subtract goes negative
                    rem_d = div_diff[W] ? div_shift[W-1:0] : div_diff[W-1:0];
                    prod_d[W-1:0] = {prod_q[W-2:0], !div_diff[W]};
                end else begin
                    prod_d = {mul_sum, prod_q[W-1:1]};
                end
                if (cnt_q == CNT_LAST) state_d = S_FIXUP;
            end
            S_FIXUP: begin
                res_d   = fix_res;
                state_d = S_DONE;
            end
            S_DONE: begin
                result_d = res_q;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (state_q != S_IDLE && bus.flush) begin
            state_d  = S_IDLE;
            res_d    = res_q;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            rd_q     <= '0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            opnd_q   <= '0;
            prod_q   <= '0;
            rem_q    <= '0;
            res_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            rd_q     <= rd_d;
            neg_a_q  <= neg_a_d;
            neg_b_q  <= neg_b_d;
            opnd_q   <= opnd_d;
            prod_q   <= prod_d;
            rem_q    <= rem_d;
            res_q    <= res_d;
            result_q <= result_d;
        end
    end

    // During DONE the fresh result is visible; result_q takes it only if the cycle completes
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.done      = (state_q == S_DONE) && !bus.flush;
    assign bus.reg_wen   = bus.done;
    assign bus.reg_waddr = rd_q;
    assign bus.result    = (state_q == S_DONE) ? res_q : result_q;
endmodule

// File: tb/tb_mdu_ctrl.sv
// tb/tb_mdu_ctrl.sv - directed self-checking bench for mdu_ctrl
module tb_mdu_ctrl;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    mdu_ctrl_if #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) bus ();

    mdu_ctrl #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .CNT_WIDTH(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic [31:0] exp, input int exp_lat,
                          input string nm);
        int n;
        bit found;
        @(posedge clk); #1;
        bus.start = 1'b1; bus.op = o; bus.rs1_data = a; bus.rs2_data = b; bus.rd_addr = rd;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.rs1_data = $urandom; bus.rs2_data = $urandom; bus.rd_addr = 5'($urandom);
        n = 1; found = 1'b0;
        while (n <= 40 && !found) begin
            @(negedge clk);
            if (n == 1) begin
                total++;
                if (bus.busy !== 1'b1) begin bad++; $display("FAIL %s busy_after_start got=%b want=1", nm, bus.busy); end
            end
            if (bus.done === 1'b1) found = 1'b1;
            else n++;
        end
        total++;
        if (!found || n != exp_lat) begin bad++; $display("FAIL %s latency got=%0d want=%0d (found=%0b)", nm, n, exp_lat, found); end
        total++;
        if (bus.result !== exp) begin bad++; $display("FAIL %s result got=%h want=%h", nm, bus.result, exp); end
        total++;
        if (bus.reg_waddr !== rd || bus.reg_wen !== 1'b1) begin
            bad++; $display("FAIL %s writeback got waddr=%0d wen=%b want waddr=%0d wen=1", nm, bus.reg_waddr, bus.reg_wen, rd);
        end
        @(negedge clk);
        total++;
        if (bus.done !== 1'b0 || bus.reg_wen !== 1'b0 || bus.busy !== 1'b0 || bus.result !== exp) begin
            bad++; $display("FAIL %s after_done got done=%b wen=%b busy=%b result=%h want 0/0/0/%h",
                            nm, bus.done, bus.reg_wen, bus.busy, bus.result, exp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        total++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.reg_wen !== 1'b0 || bus.reg_waddr !== 5'd0 || bus.result !== 32'd0) begin
            bad++; $display("FAIL reset got busy=%b done=%b wen=%b waddr=%0d result=%h want all zero",
                            bus.busy, bus.done, bus.reg_wen, bus.reg_waddr, bus.result);
        end
    endtask

    task automatic test_mul();
        run_op(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd9, 32'hFFFF_FFEB, 34, "mul_7xm3");
    endtask

    task automatic test_mul_high();
        run_op(3'b001, 32'h8000_0000, 32'h8000_0000, 5'd10, 32'h4000_0000, 34, "mulh_min");
        run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd11, 32'hFFFF_FFFE, 34, "mulhu_max");
        run_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd12, 32'hFFFF_FFFF, 34, "mulhsu_m1");
    endtask

    task automatic test_div();
        run_op(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd13, 32'hFFFF_FFFD, 34, "div_m7_2");
        run_op(3'b110, 32'hFFFF_FFF9, 32'd2, 5'd14, 32'hFFFF_FFFF, 34, "rem_m7_2");
        run_op(3'b101, 32'd100, 32'd7, 5'd15, 32'd14, 34, "divu_100_7");
        run_op(3'b111, 32'd100, 32'd7, 5'd16, 32'd2, 34, "remu_100_7");
    endtask

    task automatic test_div_special();
        run_op(3'b101, 32'd5, 32'd0, 5'd17, 32'hFFFF_FFFF, 1, "divu_by0");
        run_op(3'b110, 32'd5, 32'd0, 5'd18, 32'd5, 1, "rem_by0");
        run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd19, 32'h8000_0000, 1, "div_ovf");
        run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd20, 32'd0, 1, "rem_ovf");
    endtask

    task automatic test_flush();
        int dones;
        run_op(3'b101, 32'd100, 32'd7, 5'd21, 32'd14, 34, "flush_prep");
        @(posedge clk); #1;
        bus.start = 1'b1; bus.op = 3'b000; bus.rs1_data = 32'd6; bus.rs2_data = 32'd6; bus.rd_addr = 5'd22;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #1 bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        total++;
        if (bus.busy !== 1'b0 || bus.result !== 32'd14) begin
            bad++; $display("FAIL flush_abort got busy=%b result=%h want busy=0 result=0000000e", bus.busy, bus.result);
        end
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1 || bus.reg_wen === 1'b1) dones++;
        end
        total++;
        if (dones != 0 || bus.result !== 32'd14) begin
            bad++; $display("FAIL flush_no_done got dones=%0d result=%h want 0 and 0000000e", dones, bus.result);
        end
    endtask

    task automatic test_busy_ignore();
        int dones;
        int at;
        @(posedge clk); #1;
        bus.start = 1'b1; bus.op = 3'b000; bus.rs1_data = 32'd3; bus.rs2_data = 32'd5; bus.rd_addr = 5'd23;
        @(posedge clk); #1;
        bus.start = 1'b0;
        dones = 0; at = 0;
        for (int n = 1; n <= 45; n++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                dones++; at = n;
                total++;
                if (bus.result !== 32'd15 || bus.reg_waddr !== 5'd23) begin
                    bad++; $display("FAIL ignore_result got result=%h waddr=%0d want 0000000f/23", bus.result, bus.reg_waddr);
                end
            end
            if (n == 5) begin
                bus.start = 1'b1; bus.op = 3'b101; bus.rs1_data = 32'd9; bus.rs2_data = 32'd0; bus.rd_addr = 5'd24;
            end
            if (n == 6) bus.start = 1'b0;
        end
        total++;
        if (dones != 1 || at != 34) begin
            bad++; $display("FAIL ignore_count got dones=%0d at=%0d want 1 at 34", dones, at);
        end
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        bus.start = 1'b1; bus.op = 3'b000; bus.rs1_data = 32'd11; bus.rs2_data = 32'd13; bus.rd_addr = 5'd25;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        total++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.reg_wen !== 1'b0 || bus.reg_waddr !== 5'd0 || bus.result !== 32'd0) begin
            bad++; $display("FAIL reset_mid got busy=%b done=%b wen=%b waddr=%0d result=%h want all zero",
                            bus.busy, bus.done, bus.reg_wen, bus.reg_waddr, bus.result);
        end
        run_op(3'b000, 32'd3, 32'd4, 5'd26, 32'd12, 34, "mul_after_rst");
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus.start = 1'b0; bus.op = 3'b000; bus.rs1_data = '0; bus.rs2_data = '0;
        bus.rd_addr = '0; bus.flush = 1'b0;
        test_reset();
        test_mul();
        test_mul_high();
        test_div();
        test_div_special();
        test_flush();
        test_busy_ignore();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
